// File: rtl/sa_pkg.sv
// -----------------------------------------------------------------------------
// sa_pkg
// Shared types and helpers for the streaming systolic MAC array.
//   sa_state_t : job sequencer states (IDLE, LOAD, DRAIN, DONE)
//   sa_acc_w   : accumulator width that holds K_MAX full-width products
// -----------------------------------------------------------------------------
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sa_state_t;

    function automatic int sa_acc_w(input int wl, input int k_max);
        return 2 * wl + $clog2(k_max);
    endfunction

endpackage

// File: rtl/sa_pe.sv
// -----------------------------------------------------------------------------
// sa_pe
// One output-stationary MAC cell of the systolic grid.
// Optional build macro: SA_APPROX_MUL_EN (truncate APPROX_LSB product LSBs).
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-low reset
//   clear  in   zero the accumulator (start of a new job)
//   a_in   in   A operand arriving from the left
//   b_in   in   B operand arriving from above
//   a_out  out  a_in registered, forwarded to the right neighbour
//   b_out  out  b_in registered, forwarded to the neighbour below
//   acc    out  running sum of products
// -----------------------------------------------------------------------------
module sa_pe #(
    parameter int WL         = 8,
    parameter int ACC_W      = 22,
    parameter int APPROX_LSB = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WL-1:0]    a_in,
    input  logic [WL-1:0]    b_in,
    output logic [WL-1:0]    a_out,
    output logic [WL-1:0]    b_out,
    output logic [ACC_W-1:0] acc
);

    logic [2*WL-1:0] prod;

    if (APPROX_LSB < 0 || APPROX_LSB > 2 * WL) begin : g_lsb_check
        $error("sa_pe: APPROX_LSB must lie in 0..2*WL");
    end

`ifdef SA_APPROX_MUL_EN
    // Truncated multiplier: the low APPROX_LSB product bits are dropped.
    function automatic logic [2*WL-1:0] trunc_lsb(input logic [2*WL-1:0] p);
        return p & ({(2*WL){1'b1}} << APPROX_LSB);
    endfunction

    assign prod = trunc_lsb((2*WL)'(a_in) * (2*WL)'(b_in));
`else
    assign prod = (2*WL)'(a_in) * (2*WL)'(b_in);
`endif

    // Stage boundary: operand forwarding and accumulation
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            if (clear) acc <= '0;
            else       acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/systolic_array_stream.sv
// -----------------------------------------------------------------------------
// systolic_array_stream
// Output-stationary ROWS x COLS systolic array computing C = A * B for a
// runtime inner dimension K (1..K_MAX), fed one k-slice per handshake beat.
// Optional build macro: SA_APPROX_MUL_EN (truncated products in every PE).
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-low reset
//   start     in   begin a job (honoured in IDLE or DONE)
//   k_len     in   inner dimension, sampled on the accepted start
//   a_col     in   A[i][k] at [i*WL +: WL]
//   b_row     in   B[k][j] at [j*WL +: WL]
//   in_valid  in   a_col/b_row carry slice k
//   in_ready  out  high only while loading
//   busy      out  high in LOAD or DRAIN
//   done      out  one-cycle pulse when res is final
//   res       out  C[i][j] at [(i*COLS+j)*ACC_W +: ACC_W]
//   cycle     out  clock cycles elapsed in the current job
// -----------------------------------------------------------------------------
module systolic_array_stream
    import sa_pkg::*;
#(
    parameter int ROWS       = 3,
    parameter int COLS       = 3,
    parameter int WL         = 8,
    parameter int K_MAX      = 64,
    parameter int KW         = $clog2(K_MAX + 1),
    parameter int ACC_W      = sa_acc_w(WL, K_MAX),
    parameter int APPROX_LSB = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [KW-1:0]               k_len,
    input  logic [ROWS*WL-1:0]          a_col,
    input  logic [COLS*WL-1:0]          b_row,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        busy,
    output logic                        done,
    output logic [ROWS*COLS*ACC_W-1:0]  res,
    output logic [31:0]                 cycle
);

    // DRAIN lasts ROWS+COLS cycles so that done lands exactly ROWS+COLS
    // edges after the last beat, once the far corner PE has accumulated.
    localparam int DRAIN_LAST = ROWS + COLS - 1;
    localparam int DW         = $clog2(ROWS + COLS + 1);

    sa_state_t       state, state_next;
    logic [KW-1:0]   k_eff;
    logic [KW-1:0]   k_clamped;
    logic [KW-1:0]   beat_cnt;
    logic [DW-1:0]   drain_cnt;
    logic            start_ok;
    logic            beat_ok;
    logic            last_beat;
    logic            drain_end;
    logic            enter_done;

    logic [ROWS*WL-1:0] a_inj;
    logic [COLS*WL-1:0] b_inj;

    logic [WL-1:0] a_h [ROWS][COLS+1];
    logic [WL-1:0] b_v [ROWS+1][COLS];

    assign in_ready = (state == LOAD);
    assign busy     = (state == LOAD) || (state == DRAIN);

    // Cycles without an accepted beat inject zeros, which add nothing.
    assign a_inj = beat_ok ? a_col : '0;
    assign b_inj = beat_ok ? b_row : '0;

    always_comb begin
        state_next = state;
        k_clamped  = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
        start_ok   = start && ((state == IDLE) || (state == DONE));
        beat_ok    = in_valid && (state == LOAD);
        last_beat  = beat_ok && (beat_cnt == k_eff - KW'(1));
        drain_end  = (state == DRAIN) && (drain_cnt == DW'(DRAIN_LAST));
        enter_done = drain_end || (start_ok && (k_clamped == '0));
        case (state)
            IDLE, DONE: begin
                if (start_ok) state_next = (k_clamped == '0) ? DONE : LOAD;
            end
            LOAD: begin
                if (last_beat) state_next = DRAIN;
            end
            DRAIN: begin
                if (drain_end) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            k_eff     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            cycle     <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_next;
            done  <= enter_done;
            if (start_ok) begin
                k_eff    <= k_clamped;
                beat_cnt <= '0;
                cycle    <= '0;
            end else begin
                if (busy)    cycle    <= cycle + 32'd1;
                if (beat_ok) beat_cnt <= beat_cnt + KW'(1);
            end
            if (state == DRAIN) drain_cnt <= drain_cnt + DW'(1);
            else                drain_cnt <= '0;
        end
    end

    // Stage boundary: input skew, row i of A delayed i cycles
    for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
        if (i == 0) begin : g_direct
            assign a_h[0][0] = a_inj[0 +: WL];
        end else begin : g_dly
            logic [WL-1:0] dly [i];
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int s = 0; s < i; s++) dly[s] <= '0;
                end else begin
                    dly[0] <= a_inj[i*WL +: WL];
                    for (int s = 1; s < i; s++) dly[s] <= dly[s-1];
                end
            end
            assign a_h[i][0] = dly[i-1];
        end
    end

    // Stage boundary: input skew, column j of B delayed j cycles
    for (genvar j = 0; j < COLS; j++) begin : g_b_skew
        if (j == 0) begin : g_direct
            assign b_v[0][0] = b_inj[0 +: WL];
        end else begin : g_dly
            logic [WL-1:0] dly [j];
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int s = 0; s < j; s++) dly[s] <= '0;
                end else begin
                    dly[0] <= b_inj[j*WL +: WL];
                    for (int s = 1; s < j; s++) dly[s] <= dly[s-1];
                end
            end
            assign b_v[0][j] = dly[j-1];
        end
    end

    // Stage boundary: PE grid, one register hop per neighbour
    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            sa_pe #(
                .WL         (WL),
                .ACC_W      (ACC_W),
                .APPROX_LSB (APPROX_LSB)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clear (start_ok),
                .a_in  (a_h[i][j]),
                .b_in  (b_v[i][j]),
                .a_out (a_h[i][j+1]),
                .b_out (b_v[i+1][j]),
                .acc   (res[(i*COLS+j)*ACC_W +: ACC_W])
            );
        end
    end

endmodule

// File: tb/tb_systolic_array_stream.sv
// -----------------------------------------------------------------------------
// tb_systolic_array_stream
// Directed bench for systolic_array_stream (3x3, WL=8, K_MAX=64).
// With SA_APPROX_MUL_EN defined the approximate-product scenario runs instead
// of the exact-product scenarios.
// -----------------------------------------------------------------------------
module tb_systolic_array_stream;

    localparam int ROWS  = 3;
    localparam int COLS  = 3;
    localparam int WL    = 8;
    localparam int K_MAX = 64;
    localparam int KW    = 7;
    localparam int ACC_W = 22;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start;
    logic [KW-1:0]              k_len;
    logic [ROWS*WL-1:0]         a_col;
    logic [COLS*WL-1:0]         b_row;
    logic                       in_valid;
    logic                       in_ready;
    logic                       busy;
    logic                       done;
    logic [ROWS*COLS*ACC_W-1:0] res;
    logic [31:0]                cycle;

    int errors = 0;
    int checks = 0;

    int a_m [ROWS][K_MAX];
    int b_m [K_MAX][COLS];

    always #5 clk = ~clk;

    systolic_array_stream #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .WL         (WL),
        .K_MAX      (K_MAX),
        .KW         (KW),
        .ACC_W      (ACC_W),
        .APPROX_LSB (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .k_len    (k_len),
        .a_col    (a_col),
        .b_row    (b_row),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .res      (res),
        .cycle    (cycle)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ACC_W-1:0] res_at(input int i, input int j);
        return res[(i*COLS+j)*ACC_W +: ACC_W];
    endfunction

    task automatic fill_const(input int v);
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < K_MAX; k++) a_m[i][k] = v;
        for (int k = 0; k < K_MAX; k++)
            for (int j = 0; j < COLS; j++) b_m[k][j] = v;
    endtask

    // A[i][k] = i+k+1, B = identity in its top 3x3 block, zero below.
    task automatic fill_identity();
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < K_MAX; k++) a_m[i][k] = i + k + 1;
        for (int k = 0; k < K_MAX; k++)
            for (int j = 0; j < COLS; j++) b_m[k][j] = (k == j) ? 1 : 0;
    endtask

    task automatic start_job(input int k);
        start = 1'b1;
        k_len = KW'(k);
        tick();
        start = 1'b0;
    endtask

    // Presents slices until k are accepted or LOAD ends; gaps uses 1,0,0 valid.
    task automatic stream(input int k, input bit gaps, output int got, output int ready_bad);
        int t;
        bit took;
        t = 0;
        got = 0;
        ready_bad = 0;
        while (got < k && t < 400 && !(got > 0 && in_ready !== 1'b1)) begin
            in_valid = gaps ? (t % 3 == 0) : 1'b1;
            for (int i = 0; i < ROWS; i++) a_col[i*WL +: WL] = WL'(a_m[i][got % K_MAX]);
            for (int j = 0; j < COLS; j++) b_row[j*WL +: WL] = WL'(b_m[got % K_MAX][j]);
            if (in_ready !== 1'b1) ready_bad++;
            took = in_valid && (in_ready === 1'b1);
            tick();
            t++;
            if (took) got++;
        end
        in_valid = 1'b0;
        a_col = '0;
        b_row = '0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; k_len = '0; a_col = '0; b_row = '0;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", in_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (cycle !== 32'd0) begin errors++; $display("FAIL reset_cycle: got %0d expected 0", cycle); end
        checks++; if (res !== '0) begin errors++; $display("FAIL reset_res: got %0h expected 0", res); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_identity();
        int got, bad, n;
        fill_identity();
        start_job(6);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL ident_load: busy %0b ready %0b expected 1 1", busy, in_ready); end
        checks++; if (cycle !== 32'd0) begin errors++; $display("FAIL ident_cycle0: got %0d expected 0", cycle); end
        stream(6, 1'b0, got, bad);
        checks++; if (got != 6) begin errors++; $display("FAIL ident_beats: got %0d expected 6", got); end
        wait_done(n);
        checks++; if (n != 6) begin errors++; $display("FAIL ident_latency: got %0d expected 6", n); end
        checks++; if (cycle !== 32'd12) begin errors++; $display("FAIL ident_cycle: got %0d expected 12", cycle); end
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                checks++;
                if (res_at(i, j) !== ACC_W'(i + j + 1)) begin
                    errors++; $display("FAIL ident_res[%0d][%0d]: got %0d expected %0d", i, j, res_at(i, j), i + j + 1);
                end
            end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ident_done_pulse: got %0b expected 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ident_idle_busy: got %0b expected 0", busy); end
        checks++; if (cycle !== 32'd12) begin errors++; $display("FAIL ident_cycle_hold: got %0d expected 12", cycle); end
        checks++; if (res_at(2, 2) !== ACC_W'(5)) begin errors++; $display("FAIL ident_res_hold: got %0d expected 5", res_at(2, 2)); end
    endtask

    task automatic test_kmax();
        int got, bad, n;
        fill_const(255);
        start_job(64);
        stream(64, 1'b0, got, bad);
        checks++; if (got != 64) begin errors++; $display("FAIL kmax_beats: got %0d expected 64", got); end
        wait_done(n);
        checks++; if (n != 6) begin errors++; $display("FAIL kmax_latency: got %0d expected 6", n); end
        checks++; if (cycle !== 32'd70) begin errors++; $display("FAIL kmax_cycle: got %0d expected 70", cycle); end
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                checks++;
                if (res_at(i, j) !== ACC_W'(4161600)) begin
                    errors++; $display("FAIL kmax_res[%0d][%0d]: got %0d expected 4161600", i, j, res_at(i, j));
                end
            end
        // k_len above K_MAX is clamped: only 64 beats are taken
        fill_const(1);
        start_job(100);
        stream(100, 1'b0, got, bad);
        checks++; if (got != 64) begin errors++; $display("FAIL clamp_beats: got %0d expected 64", got); end
        wait_done(n);
        checks++; if (n != 6) begin errors++; $display("FAIL clamp_latency: got %0d expected 6", n); end
        checks++; if (res_at(1, 2) !== ACC_W'(64)) begin errors++; $display("FAIL clamp_res: got %0d expected 64", res_at(1, 2)); end
    endtask

    task automatic test_gaps();
        int got, bad, n;
        fill_identity();
        start_job(6);
        stream(6, 1'b1, got, bad);
        checks++; if (got != 6) begin errors++; $display("FAIL gaps_beats: got %0d expected 6", got); end
        checks++; if (bad != 0) begin errors++; $display("FAIL gaps_ready: low for %0d cycles, expected 0", bad); end
        wait_done(n);
        checks++; if (n != 6) begin errors++; $display("FAIL gaps_latency: got %0d expected 6", n); end
        checks++; if (cycle !== 32'd22) begin errors++; $display("FAIL gaps_cycle: got %0d expected 22", cycle); end
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                checks++;
                if (res_at(i, j) !== ACC_W'(i + j + 1)) begin
                    errors++; $display("FAIL gaps_res[%0d][%0d]: got %0d expected %0d", i, j, res_at(i, j), i + j + 1);
                end
            end
    endtask

    task automatic test_zero_k();
        start_job(0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zk_done: got %0b expected 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zk_busy: got %0b expected 0", busy); end
        checks++; if (res !== '0) begin errors++; $display("FAIL zk_res: got %0h expected 0", res); end
        checks++; if (cycle !== 32'd0) begin errors++; $display("FAIL zk_cycle: got %0d expected 0", cycle); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zk_after: done %0b busy %0b expected 0 0", done, busy); end
    endtask

    task automatic test_reset_midjob();
        int got, bad, dcount, cyc_at;
        logic [ROWS*COLS*ACC_W-1:0] snap;
        fill_identity();
        start_job(6);
        stream(2, 1'b0, got, bad);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rmid_state: busy %0b ready %0b expected 0 0", busy, in_ready); end
        checks++; if (res !== '0) begin errors++; $display("FAIL rmid_res: got %0h expected 0", res); end
        checks++; if (cycle !== 32'd0 || done !== 1'b0) begin errors++; $display("FAIL rmid_cycle_done: cycle %0d done %0b expected 0 0", cycle, done); end
        fill_const(1);
        start_job(2);
        stream(2, 1'b0, got, bad);
        // in DRAIN now: this start must be ignored
        start = 1'b1;
        k_len = KW'(5);
        tick();
        start = 1'b0;
        dcount = 0;
        cyc_at = -1;
        snap = '0;
        for (int t = 0; t < 15; t++) begin
            if (done === 1'b1) begin
                dcount++;
                snap = res;
                cyc_at = int'(cycle);
            end
            tick();
        end
        checks++; if (dcount != 1) begin errors++; $display("FAIL rmid_done_count: got %0d expected 1", dcount); end
        checks++; if (cyc_at != 8) begin errors++; $display("FAIL rmid_cycle: got %0d expected 8", cyc_at); end
        for (int i = 0; i < ROWS * COLS; i++) begin
            checks++;
            if (snap[i*ACC_W +: ACC_W] !== ACC_W'(2)) begin
                errors++; $display("FAIL rmid_res[%0d]: got %0d expected 2", i, snap[i*ACC_W +: ACC_W]);
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle: busy %0b expected 0", busy); end
    endtask

    task automatic test_approx();
        int got, bad, n;
        fill_const(15);
        start_job(1);
        stream(1, 1'b0, got, bad);
        checks++; if (got != 1) begin errors++; $display("FAIL approx_beats: got %0d expected 1", got); end
        wait_done(n);
        checks++; if (n != 6) begin errors++; $display("FAIL approx_latency: got %0d expected 6", n); end
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                checks++;
                if (res_at(i, j) !== ACC_W'(224)) begin
                    errors++; $display("FAIL approx_res[%0d][%0d]: got %0d expected 224", i, j, res_at(i, j));
                end
            end
    endtask

    initial begin
        test_reset();
`ifdef SA_APPROX_MUL_EN
        test_approx();
`else
        test_identity();
        test_kmax();
        test_gaps();
        test_zero_k();
        test_reset_midjob();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
